// File: rtl/tensor_stream_arbiter.sv
// Two-requester tensor stream arbiter: a grant is held for a whole tensor, output is one register stage.
// Build option TENSOR_ARB_FIXED_PRIORITY_EN: requester 0 always wins arbitration (default is round-robin).
module tensor_stream_arbiter #(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_1 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                             data_in_1_valid,
  output logic                             data_in_1_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready,
  output logic                             data_out_0_src,
  output logic                             data_out_0_last
);

  localparam int NUM_ELEM = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int DEPTH    = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                            (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  // Elaboration-time sanity on the shape and fixed-point metadata.
  generate
    if (DEPTH < 1 || DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_param
      $error("tensor_stream_arbiter: DEPTH must be >= 1 and fractional bits <= element width");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GRANT_0, GRANT_1} state_t;

  state_t                           state_reg;
  state_t                           state_next;
  logic [CNT_W-1:0]                 beat_cnt_reg;
  logic [DATA_IN_0_PRECISION_0-1:0] out_data_reg [NUM_ELEM];
  logic                             out_valid_reg;
  logic                             out_src_reg;
  logic                             out_last_reg;

  logic out_free;
  logic accept_0;
  logic accept_1;
  logic accept;
  logic tensor_done;
  logic any_valid;
  logic winner;

  assign out_free    = !out_valid_reg || data_out_0_ready;
  assign accept_0    = data_in_0_valid && data_in_0_ready;
  assign accept_1    = data_in_1_valid && data_in_1_ready;
  assign accept      = accept_0 || accept_1;
  assign tensor_done = accept && (beat_cnt_reg == LAST_CNT);
  assign any_valid   = data_in_0_valid || data_in_1_valid;

`ifdef TENSOR_ARB_FIXED_PRIORITY_EN
  assign winner = !data_in_0_valid;
`else
  logic last_grant_reg;

  // With both requesting, the one not served last time wins.
  assign winner = (data_in_0_valid && data_in_1_valid) ? !last_grant_reg : !data_in_0_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == IDLE && any_valid) begin
      last_grant_reg <= winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:             if (any_valid) state_next = winner ? GRANT_1 : GRANT_0;
      GRANT_0, GRANT_1: if (tensor_done) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_comb begin
    data_in_0_ready = 1'b0;
    data_in_1_ready = 1'b0;
    case (state_reg)
      GRANT_0: data_in_0_ready = out_free;
      GRANT_1: data_in_1_ready = out_free;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else if (accept) begin
      beat_cnt_reg <= tensor_done ? '0 : beat_cnt_reg + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
      always_ff @(posedge clk) begin
        if (rst) begin
          out_data_reg[gi] <= '0;
        end else if (accept) begin
          out_data_reg[gi] <= accept_1 ? data_in_1[gi] : data_in_0[gi];
        end
      end
      assign data_out_0[gi] = out_data_reg[gi];
    end
  endgenerate

  // Control side of the output stage; src/last only change when a new beat lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_src_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_src_reg   <= accept_1;
      out_last_reg  <= (beat_cnt_reg == LAST_CNT);
    end else if (data_out_0_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign data_out_0_valid = out_valid_reg;
  assign data_out_0_src   = out_src_reg;
  assign data_out_0_last  = out_last_reg;

endmodule

// File: tb/tb_tensor_stream_arbiter.sv
// Scoreboard bench: a DEPTH=4 instance for ordering, stalls, locking and reset, plus a DEPTH=1 instance.
module tb_tensor_stream_arbiter;

  localparam int W = 16;
  localparam int N = 4;
  localparam int D = 4;

`ifdef TENSOR_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef logic [N*W-1:0] beat_t;
  typedef struct packed {
    beat_t data;
    logic  src;
    logic  last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] d0 [N];
  logic [W-1:0] d1 [N];
  logic [W-1:0] q  [N];
  logic v0, v1, r0, r1, ov, ordy, osrc, olast;

  logic [W-1:0] a_d0 [N];
  logic [W-1:0] a_d1 [N];
  logic [W-1:0] a_q  [N];
  logic a_v0, a_v1, a_r0, a_r1, a_ov, a_ordy, a_osrc, a_olast;

  tensor_stream_arbiter #(
    .DATA_IN_0_PRECISION_0(W), .DATA_IN_0_PRECISION_1(3),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(16), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
    .DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_IN_0_PARALLELISM_DIM_1(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .data_in_0(d0), .data_in_0_valid(v0), .data_in_0_ready(r0),
    .data_in_1(d1), .data_in_1_valid(v1), .data_in_1_ready(r1),
    .data_out_0(q), .data_out_0_valid(ov), .data_out_0_ready(ordy),
    .data_out_0_src(osrc), .data_out_0_last(olast)
  );

  tensor_stream_arbiter u_dut_d1 (
    .clk(clk), .rst(rst),
    .data_in_0(a_d0), .data_in_0_valid(a_v0), .data_in_0_ready(a_r0),
    .data_in_1(a_d1), .data_in_1_valid(a_v1), .data_in_1_ready(a_r1),
    .data_out_0(a_q), .data_out_0_valid(a_ov), .data_out_0_ready(a_ordy),
    .data_out_0_src(a_osrc), .data_out_0_last(a_olast)
  );

  int vectors = 0;
  int miscompares = 0;

  beat_t src_q0[$];
  beat_t src_q1[$];
  exp_t  exp_q[$];
  bit    en0, en1, out_rdy_pat;
  int    sent0, sent1;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  function automatic beat_t make_beat(input int src, input int t, input int b);
    beat_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(src*4096 + t*64 + b*4 + i);
    return r;
  endfunction

  function automatic beat_t pack_q();
    beat_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = q[i];
    return r;
  endfunction

  function automatic beat_t pack_a_q();
    beat_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = a_q[i];
    return r;
  endfunction

  task automatic push_exp(input int src, input int t);
    exp_t e;
    for (int b = 0; b < D; b++) begin
      e.data = make_beat(src, t, b);
      e.src  = src[0];
      e.last = (b == D - 1);
      exp_q.push_back(e);
    end
  endtask

  // Both requesters get `count` tensors; expected order follows the arbitration policy.
  task automatic plan_tensors(input int t0, input int count);
    for (int t = t0; t < t0 + count; t++)
      for (int b = 0; b < D; b++) begin
        src_q0.push_back(make_beat(0, t, b));
        src_q1.push_back(make_beat(1, t, b));
      end
    if (FIXED) begin
      for (int t = t0; t < t0 + count; t++) push_exp(0, t);
      for (int t = t0; t < t0 + count; t++) push_exp(1, t);
    end else begin
      for (int t = t0; t < t0 + count; t++) begin
        push_exp(0, t);
        push_exp(1, t);
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    v0 = en0 && (src_q0.size() > 0);
    if (v0) for (int i = 0; i < N; i++) d0[i] = src_q0[0][i*W +: W];
    v1 = en1 && (src_q1.size() > 0);
    if (v1) for (int i = 0; i < N; i++) d1[i] = src_q1[0][i*W +: W];
    ordy = out_rdy_pat;
    #1;
    if (ov) begin
      if (exp_q.size() == 0) begin
        expect_eq("spurious_out", 64'(ov), 64'd0);
      end else begin
        e = exp_q[0];
        expect_eq("out_data", 64'(pack_q()), 64'(e.data));
        expect_eq("out_src", 64'(osrc), 64'(e.src));
        expect_eq("out_last", 64'(olast), 64'(e.last));
        if (ordy) void'(exp_q.pop_front());
      end
    end
    expect_eq("ready_excl", 64'(r0 && r1), 64'd0);
    if (ov && !ordy) expect_eq("stall_ready", 64'(r0 || r1), 64'd0);
    if (v0 && r0) begin void'(src_q0.pop_front()); sent0++; end
    if (v1 && r1) begin void'(src_q1.pop_front()); sent1++; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b_exp;
    int cyc, drop0, drop1, guard;
    bit dropped0, dropped1;
    bit exp_src;

    v0 = 0; v1 = 0; ordy = 0; a_v0 = 0; a_v1 = 0; a_ordy = 0;
    en0 = 1; en1 = 1; out_rdy_pat = 1; sent0 = 0; sent1 = 0;
    for (int i = 0; i < N; i++) begin
      d0[i] = '0; d1[i] = '0; a_d0[i] = '0; a_d1[i] = '0;
    end
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    expect_eq("rst_valid", 64'(ov), 64'd0);
    expect_eq("rst_src", 64'(osrc), 64'd0);
    expect_eq("rst_last", 64'(olast), 64'd0);
    expect_eq("rst_data", 64'(pack_q()), 64'd0);
    expect_eq("rst_ready0", 64'(r0), 64'd0);
    expect_eq("rst_ready1", 64'(r1), 64'd0);
    expect_eq("d1_rst_valid", 64'(a_ov), 64'd0);

    // DEPTH=1: one bubble cycle, then accept; every beat is last.
    @(negedge clk);
    a_v0 = 1; a_ordy = 1;
    a_d0[0] = 16'd1; a_d0[1] = 16'd2; a_d0[2] = 16'd3; a_d0[3] = 16'd4;
    #1 expect_eq("d1_idle_ready", 64'(a_r0), 64'd0);
    @(negedge clk); #1;
    expect_eq("d1_grant_ready", 64'(a_r0), 64'd1);
    expect_eq("d1_bubble_valid", 64'(a_ov), 64'd0);
    @(negedge clk); a_v0 = 0; #1;
    b_exp = {16'd4, 16'd3, 16'd2, 16'd1};
    expect_eq("d1_valid", 64'(a_ov), 64'd1);
    expect_eq("d1_data", 64'(pack_a_q()), 64'(b_exp));
    expect_eq("d1_src", 64'(a_osrc), 64'd0);
    expect_eq("d1_last", 64'(a_olast), 64'd1);
    expect_eq("d1_back_idle_ready", 64'(a_r0), 64'd0);

    // DEPTH=1, both requesting: round-robin now favours requester 1.
    @(negedge clk);
    a_v0 = 1; a_v1 = 1;
    a_d0[0] = 16'd9; a_d0[1] = 16'd10; a_d0[2] = 16'd11; a_d0[3] = 16'd12;
    a_d1[0] = 16'd5; a_d1[1] = 16'd6;  a_d1[2] = 16'd7;  a_d1[3] = 16'd8;
    #1 expect_eq("d1_drained", 64'(a_ov), 64'd0);
    exp_src = FIXED ? 1'b0 : 1'b1;
    b_exp = FIXED ? {16'd12, 16'd11, 16'd10, 16'd9} : {16'd8, 16'd7, 16'd6, 16'd5};
    @(negedge clk); #1;
    expect_eq("d1_rr_ready1", 64'(a_r1), 64'(exp_src));
    expect_eq("d1_rr_ready0", 64'(a_r0), 64'(!exp_src));
    @(negedge clk); a_v0 = 0; a_v1 = 0; #1;
    expect_eq("d1_rr_src", 64'(a_osrc), 64'(exp_src));
    expect_eq("d1_rr_data", 64'(pack_a_q()), 64'(b_exp));
    expect_eq("d1_rr_last", 64'(a_olast), 64'd1);

    // DEPTH=4 main run: stalls, valid drops mid-tensor, random backpressure.
    plan_tensors(0, 4);
    cyc = 0; drop0 = 0; drop1 = 0; dropped0 = 0; dropped1 = 0;
    while ((exp_q.size() > 0) && (cyc < 2000)) begin
      if (cyc >= 20 && cyc < 25) out_rdy_pat = 0;
      else if (cyc < 40)         out_rdy_pat = 1;
      else                       out_rdy_pat = ($urandom_range(0, 3) != 0);
      en0 = (drop0 == 0);
      en1 = (drop1 == 0);
      cycle();
      if (drop0 > 0) begin expect_eq("locked_out_1", 64'(r1), 64'd0); drop0--; end
      if (drop1 > 0) begin expect_eq("locked_out_0", 64'(r0), 64'd0); drop1--; end
      if (sent0 == 6 && !dropped0) begin drop0 = 4; dropped0 = 1; end
      if (sent1 == 2 && !dropped1) begin drop1 = 4; dropped1 = 1; end
      cyc++;
    end
    expect_eq("main_drain", 64'(exp_q.size()), 64'd0);
    expect_eq("main_src0_used", 64'(src_q0.size()), 64'd0);
    expect_eq("main_src1_used", 64'(src_q1.size()), 64'd0);

    // Reset after two beats of a tensor: partial tensor must vanish.
    en0 = 1; en1 = 1; out_rdy_pat = 1;
    src_q0.delete(); src_q1.delete(); exp_q.delete();
    sent0 = 0; sent1 = 0;
    plan_tensors(8, 1);
    guard = 0;
    while (sent0 < 2 && guard < 50) begin cycle(); guard++; end
    expect_eq("rst_mid_reached", 64'(sent0), 64'd2);
    @(negedge clk);
    rst = 1; v0 = 0; v1 = 0; ordy = 0;
    @(negedge clk);
    rst = 0;
    #1;
    expect_eq("mid_rst_valid", 64'(ov), 64'd0);
    expect_eq("mid_rst_src", 64'(osrc), 64'd0);
    expect_eq("mid_rst_last", 64'(olast), 64'd0);
    expect_eq("mid_rst_ready0", 64'(r0), 64'd0);
    src_q0.delete(); src_q1.delete(); exp_q.delete();
    sent0 = 0; sent1 = 0;
    plan_tensors(9, 1);
    cyc = 0;
    while ((exp_q.size() > 0) && (cyc < 500)) begin cycle(); cyc++; end
    expect_eq("post_rst_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
